// File: rtl/lsu_bus_resp_wb.sv
// Purpose: keeps outstanding LSQ bus-access metadata, formats in-order bus responses and writes them back.
// Latency: 1 cycle from an accepted bus response to a valid writeback on the output register.
// Backpressure: the output register holds until wb_arb_bus_rdy_i; while it is blocked no response is popped.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    discards every outstanding request; their late responses are dropped
//   lsq_req_*                request side: ROB index, dest preg, load/store, size, sign, byte offset
//   bus_resp_*               in-order raw doubleword responses from the bus
//   bus_wb_arb_* / wb_arb_*  completion and PRF write toward the writeback arbiter

// Small in-order FIFO with occupancy count and synchronous clear.
// Latency: head data is visible combinationally; push/pop take effect on the next edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module lsu_bus_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module lsu_bus_resp_wb #(
  parameter int XLEN               = 64,
  parameter int ROB_INDEX_WIDTH    = 6,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int DEPTH              = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          lsq_req_vld_i,
  output logic                          lsq_req_rdy_o,
  input  logic [ROB_INDEX_WIDTH-1:0]    lsq_req_rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] lsq_req_rd_addr_i,
  input  logic                          lsq_req_has_rd_i,
  input  logic [1:0]                    lsq_req_size_i,
  input  logic                          lsq_req_unsigned_i,
  input  logic [2:0]                    lsq_req_offset_i,
  input  logic                          bus_resp_vld_i,
  output logic                          bus_resp_rdy_o,
  input  logic [XLEN-1:0]               bus_resp_data_i,
  output logic                          bus_wb_arb_wb_vld_o,
  output logic [ROB_INDEX_WIDTH-1:0]    bus_wb_arb_wb_rob_index_o,
  output logic                          bus_wb_arb_prf_wb_vld_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0] bus_wb_arb_prf_wb_rd_addr_o,
  output logic [XLEN-1:0]               bus_wb_arb_prf_wb_data_o,
  input  logic                          wb_arb_bus_rdy_i
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ROB_INDEX_WIDTH-1:0]    rob_index;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd_addr;
    logic                          has_rd;
    logic [1:0]                    size;
    logic                          uns;
    logic [2:0]                    offset;
  } meta_t;

  localparam int MW = $bits(meta_t);

  meta_t           req_meta;
  meta_t           head_meta;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     occ;
  logic            req_acc;
  logic            resp_acc;
  logic            pop;

  logic                          out_vld;
  logic                          out_has_rd;
  logic [ROB_INDEX_WIDTH-1:0]    out_rob_index;
  logic [PHY_REG_ADDR_WIDTH-1:0] out_rd_addr;
  logic [XLEN-1:0]               out_data;

  // Shift the addressed bytes down, then sign/zero extend from the access size.
  // Doubleword accesses bypass the shift; misaligned offsets are not trapped here.
  function automatic logic [XLEN-1:0] fmt_data(input meta_t m, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] mask;
    logic            sbit;
    s    = d >> {m.offset, 3'b000};
    mask = '0;
    sbit = 1'b0;
    case (m.size)
      2'd0: begin mask = XLEN'({8{1'b1}});  sbit = s[7];  end
      2'd1: begin mask = XLEN'({16{1'b1}}); sbit = s[15]; end
      default: begin mask = XLEN'({32{1'b1}}); sbit = s[31]; end
    endcase
    if (!m.has_rd)           fmt_data = '0;
    else if (m.size == 2'd3) fmt_data = d;
    else                     fmt_data = (s & mask) | ({XLEN{~m.uns & sbit}} & ~mask);
  endfunction

  assign req_meta = '{rob_index: lsq_req_rob_index_i, rd_addr: lsq_req_rd_addr_i,
                      has_rd: lsq_req_has_rd_i, size: lsq_req_size_i,
                      uns: lsq_req_unsigned_i, offset: lsq_req_offset_i};

  // Slots still owed a response after a flush count against capacity, so a
  // new request never gets matched with a stale response.
  assign occ            = {1'b0, cnt} + {1'b0, drop_cnt};
  assign lsq_req_rdy_o  = ~flush & (occ < (CW+1)'(DEPTH));
  assign bus_resp_rdy_o = ~flush & ((drop_cnt != '0) |
                                    ((cnt != '0) & (~out_vld | wb_arb_bus_rdy_i)));

  assign req_acc  = lsq_req_vld_i & lsq_req_rdy_o;
  assign resp_acc = bus_resp_vld_i & bus_resp_rdy_o;
  assign pop      = resp_acc & (drop_cnt == '0);

  lsu_bus_resp_fifo #(.W(MW), .DEPTH(DEPTH), .CW(CW)) u_meta_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push     (req_acc),
    .push_dat (req_meta),
    .pop      (pop),
    .pop_dat  (head_meta),
    .cnt      (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst)                              drop_cnt <= '0;
    else if (flush)                       drop_cnt <= drop_cnt + cnt;
    else if (resp_acc && drop_cnt != '0)  drop_cnt <= drop_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld       <= 1'b0;
      out_has_rd    <= 1'b0;
      out_rob_index <= '0;
      out_rd_addr   <= '0;
      out_data      <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (pop) begin
      out_vld       <= 1'b1;
      out_has_rd    <= head_meta.has_rd;
      out_rob_index <= head_meta.rob_index;
      out_rd_addr   <= head_meta.rd_addr;
      out_data      <= fmt_data(head_meta, bus_resp_data_i);
    end else if (out_vld && wb_arb_bus_rdy_i) begin
      out_vld <= 1'b0;
    end
  end

  assign bus_wb_arb_wb_vld_o         = out_vld & ~flush;
  assign bus_wb_arb_wb_rob_index_o   = out_rob_index;
  assign bus_wb_arb_prf_wb_vld_o     = out_vld & out_has_rd & ~flush;
  assign bus_wb_arb_prf_wb_rd_addr_o = out_rd_addr;
  assign bus_wb_arb_prf_wb_data_o    = out_data;
endmodule

// File: tb/tb_lsu_bus_resp_wb.sv
module tb_lsu_bus_resp_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        lsq_req_vld_i;
  logic        lsq_req_rdy_o;
  logic [5:0]  lsq_req_rob_index_i;
  logic [5:0]  lsq_req_rd_addr_i;
  logic        lsq_req_has_rd_i;
  logic [1:0]  lsq_req_size_i;
  logic        lsq_req_unsigned_i;
  logic [2:0]  lsq_req_offset_i;
  logic        bus_resp_vld_i;
  logic        bus_resp_rdy_o;
  logic [63:0] bus_resp_data_i;
  logic        wb_vld;
  logic [5:0]  wb_rob;
  logic        prf_vld;
  logic [5:0]  prf_rd;
  logic [63:0] prf_data;
  logic        wb_arb_bus_rdy_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_bus_resp_wb #(.XLEN(64), .ROB_INDEX_WIDTH(6), .PHY_REG_ADDR_WIDTH(6), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsq_req_vld_i(lsq_req_vld_i), .lsq_req_rdy_o(lsq_req_rdy_o),
    .lsq_req_rob_index_i(lsq_req_rob_index_i), .lsq_req_rd_addr_i(lsq_req_rd_addr_i),
    .lsq_req_has_rd_i(lsq_req_has_rd_i), .lsq_req_size_i(lsq_req_size_i),
    .lsq_req_unsigned_i(lsq_req_unsigned_i), .lsq_req_offset_i(lsq_req_offset_i),
    .bus_resp_vld_i(bus_resp_vld_i), .bus_resp_rdy_o(bus_resp_rdy_o),
    .bus_resp_data_i(bus_resp_data_i),
    .bus_wb_arb_wb_vld_o(wb_vld), .bus_wb_arb_wb_rob_index_o(wb_rob),
    .bus_wb_arb_prf_wb_vld_o(prf_vld), .bus_wb_arb_prf_wb_rd_addr_o(prf_rd),
    .bus_wb_arb_prf_wb_data_o(prf_data), .wb_arb_bus_rdy_i(wb_arb_bus_rdy_i)
  );

  typedef struct {
    logic        has_rd;
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [5:0] rob;
    logic [5:0] rd;
    logic       has_rd;
    logic [1:0] size;
    logic       uns;
    logic [2:0] off;
  } ment_t;

  vec_t  vt[10];
  ment_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    rst = 1'b0; flush = 1'b0;
    lsq_req_vld_i = 1'b0; bus_resp_vld_i = 1'b0;
    lsq_req_rob_index_i = '0; lsq_req_rd_addr_i = '0; lsq_req_has_rd_i = 1'b0;
    lsq_req_size_i = '0; lsq_req_unsigned_i = 1'b0; lsq_req_offset_i = '0;
    bus_resp_data_i = '0;
    wb_arb_bus_rdy_i = rdy;
  endtask

  task automatic req(input logic [5:0] rob, input logic [5:0] rd, input logic has_rd,
                     input logic [1:0] size, input logic uns, input logic [2:0] off);
    lsq_req_vld_i = 1'b1; lsq_req_rob_index_i = rob; lsq_req_rd_addr_i = rd;
    lsq_req_has_rd_i = has_rd; lsq_req_size_i = size;
    lsq_req_unsigned_i = uns; lsq_req_offset_i = off;
  endtask

  // Reference formatting: pick the addressed bytes arithmetically, then extend.
  function automatic logic [63:0] efmt(input ment_t e, input logic [63:0] d);
    logic [63:0] s, mask, v;
    int bits;
    if (!e.has_rd) return 64'd0;
    if (e.size == 2'd3) return d;
    s    = d >> (8 * int'(e.off));
    bits = 8 << e.size;
    mask = (64'd1 << bits) - 64'd1;
    v    = s & mask;
    if (!e.uns && s[bits-1]) v = v | ~mask;
    return v;
  endfunction

  initial begin
    int          mdrop;
    logic        mvld;
    ment_t       mout;
    logic [63:0] mdata;

    vt[0] = '{1'b1, 2'd2, 1'b0, 3'd4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
    vt[1] = '{1'b1, 2'd0, 1'b1, 3'd7, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB};
    vt[2] = '{1'b1, 2'd1, 1'b0, 3'd2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001};
    vt[3] = '{1'b1, 2'd1, 1'b1, 3'd2, 64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001};
    vt[4] = '{1'b1, 2'd3, 1'b0, 3'd0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    vt[5] = '{1'b1, 2'd3, 1'b1, 3'd5, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};
    vt[6] = '{1'b1, 2'd0, 1'b0, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    vt[7] = '{1'b1, 2'd2, 1'b1, 3'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_CAFE_F00D};
    vt[8] = '{1'b0, 2'd3, 1'b0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    vt[9] = '{1'b1, 2'd0, 1'b0, 3'd0, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F};

    // Reset state
    idle(1'b1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_lsq_rdy", lsq_req_rdy_o, 1);
    chk("rst_resp_rdy", bus_resp_rdy_o, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_prf_vld", prf_vld, 0);
    chk("rst_data", prf_data, 0);
    chk("rst_rob", wb_rob, 0);
    chk("rst_rd", prf_rd, 0);

    // Formatting table: one request, one response, check writeback a cycle later
    for (int i = 0; i < 10; i++) begin
      req(6'(3 + i), 6'(5 + i), vt[i].has_rd, vt[i].size, vt[i].uns, vt[i].off);
      #1 chk("tbl_lsq_rdy", lsq_req_rdy_o, 1);
      step();
      lsq_req_vld_i = 1'b0;
      bus_resp_vld_i = 1'b1; bus_resp_data_i = vt[i].data;
      #1 chk("tbl_resp_rdy", bus_resp_rdy_o, 1);
      step();
      bus_resp_vld_i = 1'b0;
      chk("tbl_wb_vld", wb_vld, 1);
      chk("tbl_prf_vld", prf_vld, vt[i].has_rd);
      chk("tbl_rob", wb_rob, 64'(3 + i));
      if (vt[i].has_rd) chk("tbl_rd", prf_rd, 64'(5 + i));
      chk("tbl_data", prf_data, vt[i].exp);
      step();
      chk("tbl_clear", wb_vld, 0);
    end

    // LBU then SD, back-to-back responses, in order
    idle(1'b1);
    req(6'd1, 6'd2, 1'b1, 2'd0, 1'b1, 3'd7); step();
    req(6'd9, 6'd0, 1'b0, 2'd3, 1'b0, 3'd0); step();
    lsq_req_vld_i = 1'b0;
    bus_resp_vld_i = 1'b1; bus_resp_data_i = 64'hAB00_0000_0000_0000; step();
    chk("ord_ld_prf", prf_vld, 1);
    chk("ord_ld_data", prf_data, 64'hAB);
    chk("ord_ld_rob", wb_rob, 1);
    bus_resp_data_i = 64'h5555_AAAA_5555_AAAA; step();
    bus_resp_vld_i = 1'b0;
    chk("ord_st_wb", wb_vld, 1);
    chk("ord_st_prf", prf_vld, 0);
    chk("ord_st_data", prf_data, 0);
    chk("ord_st_rob", wb_rob, 9);
    step();

    // Fill with downstream stalled, then drain
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      req(6'(10 + i), 6'(20 + i), 1'b1, 2'd3, 1'b0, 3'd0);
      #1 chk("fill_lsq_rdy", lsq_req_rdy_o, 1);
      step();
    end
    lsq_req_vld_i = 1'b0;
    #1 chk("full_lsq_rdy", lsq_req_rdy_o, 0);
    chk("full_resp_rdy", bus_resp_rdy_o, 1);
    bus_resp_vld_i = 1'b1; bus_resp_data_i = 64'd100; step();
    bus_resp_data_i = 64'd101;
    for (int k = 0; k < 3; k++) begin
      #1 chk("stall_resp_rdy", bus_resp_rdy_o, 0);
      chk("stall_wb_vld", wb_vld, 1);
      chk("stall_rob", wb_rob, 10);
      chk("stall_data", prf_data, 100);
      step();
    end
    chk("stall_lsq_rdy", lsq_req_rdy_o, 1);
    wb_arb_bus_rdy_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus_resp_data_i = 64'(100 + i);
      #1 chk("drain_resp_rdy", bus_resp_rdy_o, 1);
      step();
      chk("drain_rob", wb_rob, 64'(10 + i));
      chk("drain_data", prf_data, 64'(100 + i));
    end
    bus_resp_vld_i = 1'b0;
    step();
    chk("drain_clear", wb_vld, 0);

    // Flush with 3 outstanding; their responses must be swallowed
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      req(6'(30 + i), 6'(30 + i), 1'b1, 2'd3, 1'b0, 3'd0); step();
    end
    lsq_req_vld_i = 1'b0; flush = 1'b1;
    #1 chk("fl_lsq_rdy", lsq_req_rdy_o, 0);
    chk("fl_resp_rdy", bus_resp_rdy_o, 0);
    step();
    flush = 1'b0;
    req(6'd40, 6'd41, 1'b1, 2'd3, 1'b0, 3'd0);
    #1 chk("fl_new_rdy", lsq_req_rdy_o, 1);
    step();
    lsq_req_vld_i = 1'b0;
    #1 chk("fl_cap_rdy", lsq_req_rdy_o, 0);
    for (int k = 0; k < 4; k++) begin
      bus_resp_vld_i = 1'b1; bus_resp_data_i = 64'(200 + k);
      #1 chk("fl_resp_rdy2", bus_resp_rdy_o, 1);
      step();
      if (k < 3) chk("fl_drop_wb", wb_vld, 0);
    end
    bus_resp_vld_i = 1'b0;
    chk("fl_wb_vld", wb_vld, 1);
    chk("fl_wb_rob", wb_rob, 40);
    chk("fl_wb_rd", prf_rd, 41);
    chk("fl_wb_data", prf_data, 203);
    step();
    chk("fl_lsq_rdy_after", lsq_req_rdy_o, 1);

    // Reset mid-operation with a held output and two entries queued
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      req(6'(50 + i), 6'(50 + i), 1'b1, 2'd3, 1'b0, 3'd0); step();
    end
    lsq_req_vld_i = 1'b0;
    bus_resp_vld_i = 1'b1; bus_resp_data_i = 64'd7; step();
    bus_resp_vld_i = 1'b0;
    chk("mid_wb_vld", wb_vld, 1);
    rst = 1'b1; step();
    rst = 1'b0;
    #1 chk("mid_rst_wb", wb_vld, 0);
    chk("mid_rst_prf", prf_vld, 0);
    chk("mid_rst_lsq_rdy", lsq_req_rdy_o, 1);
    chk("mid_rst_resp_rdy", bus_resp_rdy_o, 0);

    // Randomized traffic against a queue-based model
    idle(1'b1);
    step();
    mq.delete(); mdrop = 0; mvld = 1'b0; mdata = '0;
    mout = '{6'd0, 6'd0, 1'b0, 2'd0, 1'b0, 3'd0};
    for (int c = 0; c < 3000; c++) begin
      logic e_lrdy, e_brdy, lacc, bacc;
      ment_t n;
      flush            = ($urandom_range(0, 99) < 3);
      lsq_req_vld_i    = ($urandom_range(0, 99) < 60);
      n.rob = 6'($urandom); n.rd = 6'($urandom); n.has_rd = 1'($urandom);
      n.size = 2'($urandom); n.uns = 1'($urandom); n.off = 3'($urandom);
      req(n.rob, n.rd, n.has_rd, n.size, n.uns, n.off);
      lsq_req_vld_i    = ($urandom_range(0, 99) < 60);
      bus_resp_vld_i   = ($urandom_range(0, 99) < 60);
      bus_resp_data_i  = {$urandom, $urandom};
      wb_arb_bus_rdy_i = ($urandom_range(0, 99) < 70);
      #1;
      e_lrdy = !flush && (mq.size() + mdrop < 4);
      e_brdy = !flush && (mdrop != 0 || (mq.size() != 0 && (!mvld || wb_arb_bus_rdy_i)));
      chk("rnd_lsq_rdy", lsq_req_rdy_o, e_lrdy);
      chk("rnd_resp_rdy", bus_resp_rdy_o, e_brdy);
      chk("rnd_wb_vld", wb_vld, mvld && !flush);
      chk("rnd_prf_vld", prf_vld, mvld && mout.has_rd && !flush);
      if (mvld) begin
        chk("rnd_rob", wb_rob, mout.rob);
        chk("rnd_data", prf_data, mdata);
        if (mout.has_rd) chk("rnd_rd", prf_rd, mout.rd);
      end
      lacc = lsq_req_vld_i && e_lrdy;
      bacc = bus_resp_vld_i && e_brdy;
      if (flush) begin
        mdrop += mq.size();
        mq.delete();
        mvld = 1'b0;
      end else begin
        if (bacc) begin
          if (mdrop > 0) mdrop--;
          else begin
            mout  = mq.pop_front();
            mdata = efmt(mout, bus_resp_data_i);
            mvld  = 1'b1;
          end
        end else if (mvld && wb_arb_bus_rdy_i) begin
          mvld = 1'b0;
        end
        if (lacc) mq.push_back(n);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lsu_bus_resp_wb.md
LSU_BUS_RESP_WB -- requirements
Module: lsu_bus_resp_wb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 64, data width
- ROB_INDEX_WIDTH, 6, ROB index width
- PHY_REG_ADDR_WIDTH, 6, physical register address width
- DEPTH, 4, max outstanding bus requests (power of 2, >=2)

REQ-002 Ports, one per line: name  direction  width  meaning. One clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  sync active-high reset
- flush  in  1  pipeline flush
- lsq_req_vld_i  in  1  LSQ issues bus access
- lsq_req_rdy_o  out  1  access accepted
- lsq_req_rob_index_i  in  ROB_INDEX_WIDTH  ROB index
- lsq_req_rd_addr_i  in  PHY_REG_ADDR_WIDTH  destination preg
- lsq_req_has_rd_i  in  1  1 = load (PRF write), 0 = store
- lsq_req_size_i  in  2  0 B, 1 H, 2 W, 3 D
- lsq_req_unsigned_i  in  1  zero-extend
- lsq_req_offset_i  in  3  byte offset in doubleword
- bus_resp_vld_i  in  1  bus response valid
- bus_resp_rdy_o  out  1  response accepted
- bus_resp_data_i  in  XLEN  raw doubleword
- bus_wb_arb_wb_vld_o  out  1  LSQ completion valid
- bus_wb_arb_wb_rob_index_o  out  ROB_INDEX_WIDTH  completion ROB index
- bus_wb_arb_prf_wb_vld_o  out  1  PRF write valid
- bus_wb_arb_prf_wb_rd_addr_o  out  PHY_REG_ADDR_WIDTH  PRF address
- bus_wb_arb_prf_wb_data_o  out  XLEN  PRF data
- wb_arb_bus_rdy_i  in  1  downstream arbiter accepts

Function
REQ-003 Metadata FIFO, DEPTH entries, in order; occupancy cnt 0..DEPTH; drop counter drop_cnt 0..DEPTH.
REQ-004 lsq_req_rdy_o = ~flush & (cnt + drop_cnt < DEPTH); accept = vld & rdy; push same edge.
REQ-005 Responses are in request order; each accepted response retires exactly one outstanding request.
REQ-006 bus_resp_rdy_o = ~flush & ((drop_cnt != 0) | ((cnt != 0) & (~out_vld | wb_arb_bus_rdy_i))).
REQ-007 Accepted response with drop_cnt != 0: drop_cnt decrements, data discarded, FIFO and output untouched.
REQ-008 Accepted response with drop_cnt == 0: pop head, load output register next edge (1-cycle latency).
REQ-009 Data formatting: s = data >> (8*offset), then extend low 8/16/32 bits (size 0/1/2), sign- or zero-extended per unsigned; size 3 passes data unshifted; misalignment is not checked.
REQ-010 Store entries (has_rd=0): wb_vld asserted, prf_wb_vld low, data 0.
REQ-011 Output valid holds with stable payload until wb_arb_bus_rdy_i; on accept without a new load, out_vld clears next edge.
REQ-012 Push and pop in the same cycle leave cnt unchanged; full FIFO gives no same-cycle bypass.
REQ-013 Flush cycle: outputs wb_vld/prf_wb_vld forced 0; next edge drop_cnt <= drop_cnt + cnt, cnt <= 0, out_vld <= 0.
REQ-014 Invariant: cnt + drop_cnt <= DEPTH at all times.

Reset
REQ-015 rst: cnt=0, drop_cnt=0, out_vld=0, all outputs 0 except lsq_req_rdy_o=1 after reset; rst has priority over flush.

Verification
REQ-016 LW req offset 4, signed, rd 5, rob 3; resp 0x8000_0001_0000_0000 -> one cycle later wb_vld=1, prf_wb_vld=1, rd 5, data 0xFFFF_FFFF_8000_0001.
REQ-017 LBU offset 7 then SD; resps 0xAB00..00 and any -> wb 0x0000_00AB (prf) then store wb with prf_wb_vld=0, in order.
REQ-018 Fill 4 reqs, rdy_i=0 -> lsq_req_rdy_o=0, one response accepted then bus_resp_rdy_o=0 until rdy_i=1.
REQ-019 3 outstanding, flush, 1 new req, 4 resps -> first 3 dropped, no wb; 4th written back.
REQ-020 rst asserted mid-operation with out_vld=1 and cnt=2 -> next cycle all valids 0, cnt=0, drop_cnt=0.
